mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-requester (fetch / data) arbiter in front of a shared  |
// |               single-port memory with fixed read latency MEM_LAT.        |
// |               Define ARB_RR_EN for alternating priority on contention;   |
// |               otherwise data has fixed priority over fetch.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_type,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    localparam logic [3:0] c_CNT_LOAD = 4'(MEM_LAT - 1);
    localparam logic       c_OWNER_F  = 1'b0;
    localparam logic       c_OWNER_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_arm;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_mem_type;
    logic        r_if_rvalid;
    logic        r_d_rvalid;

    logic        w_pick_d;
    logic        w_grant_ok;

`ifdef ARB_RR_EN
    logic        r_last_owner;

    // On contention the requester that did not own the previous access wins.
    always_comb begin
        w_pick_d = d_req;
        if (d_req && if_req) begin
            w_pick_d = (r_last_owner == c_OWNER_F);
        end
    end
`else
    assign w_pick_d = d_req;
`endif

    // r_arm holds grants off until the first clock edge after reset release.
    assign w_grant_ok = (r_state == IDLE) && r_arm && (if_req || d_req);
    assign d_gnt      = w_grant_ok && (w_pick_d == c_OWNER_D);
    assign if_gnt     = w_grant_ok && (w_pick_d == c_OWNER_F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_arm        <= 1'b0;
            r_owner      <= c_OWNER_F;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_type   <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
`ifdef ARB_RR_EN
            r_last_owner <= c_OWNER_F;
`endif
        end else begin
            r_arm <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        r_owner    <= w_pick_d;
                        r_addr     <= w_pick_d ? d_addr : if_addr;
                        r_we       <= w_pick_d & d_we;
                        r_wdata    <= w_pick_d ? d_wdata : 32'd0;
                        r_cnt      <= c_CNT_LOAD;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_d & d_we;
                        r_mem_type <= w_pick_d & d_type;
                        r_state    <= ACCESS;
`ifdef ARB_RR_EN
                        r_last_owner <= w_pick_d;
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        // Read data is valid in the last access cycle; stores leave rdata alone.
                        if (!r_we) begin
                            if (r_owner == c_OWNER_D) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_if_rdata <= mem_rdata;
                            end
                        end
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_type  <= 1'b0;
                        r_if_rvalid <= (r_owner == c_OWNER_F);
                        r_d_rvalid  <= (r_owner == c_OWNER_D);
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_if_rvalid <= 1'b0;
                    r_d_rvalid  <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_type  <= 1'b0;
                    r_if_rvalid <= 1'b0;
                    r_d_rvalid  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_type  = r_mem_type;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Scoreboard bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int c_LAT0 = 2;
    localparam int c_LAT1 = 1;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] rdata;
        int          gcyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        if_req0, d_req0, d_we0, d_type0;
    logic [31:0] if_addr0, d_addr0, d_wdata0;
    logic        if_gnt0, if_rvalid0, d_gnt0, d_rvalid0;
    logic        mem_en0, mem_we0, mem_type0, busy0;
    logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

    logic        if_req1, d_req1, d_we1, d_type1;
    logic [31:0] if_addr1, d_addr1, d_wdata1;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
    logic        mem_en1, mem_we1, mem_type1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    sb_t         q0[$];
    sb_t         q1[$];
    sb_t         m0_e, m1_e;
    logic [31:0] exp_if0 = '0;
    logic [31:0] exp_d0  = '0;
    logic [31:0] exp_d1  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A00093;
        return (a * 32'h9E3779B1) ^ 32'h5555AAAA;
    endfunction

    function automatic sb_t mk(input logic owner, input logic we, input logic [31:0] rd, input int gc);
        sb_t e;
        e.owner = owner;
        e.we    = we;
        e.rdata = rd;
        e.gcyc  = gc;
        return e;
    endfunction

    // Memory returns junk whenever it is not enabled so mistimed captures show up.
    assign mem_rdata0 = mem_en0 ? memf(mem_addr0) : 32'hDEADBEEF;
    assign mem_rdata1 = mem_en1 ? memf(mem_addr1) : 32'hDEADBEEF;

    mem_arbiter #(.MEM_LAT(c_LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_gnt(if_gnt0),
        .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
        .d_req(d_req0), .d_we(d_we0), .d_type(d_type0), .d_addr(d_addr0),
        .d_wdata(d_wdata0), .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_type(mem_type0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
        .busy(busy0)
    );

    mem_arbiter #(.MEM_LAT(c_LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_type(d_type1), .d_addr(d_addr1),
        .d_wdata(d_wdata1), .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_type(mem_type1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Completions on the MEM_LAT=2 instance are matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_rvalid0 || d_rvalid0) begin
                check("rv_onehot", 32'(if_rvalid0 & d_rvalid0), 32'd0);
                check("rv_mem_en", 32'(mem_en0), 32'd0);
                if (q0.size() == 0) begin
                    check("rv_unexpected", 32'd1, 32'd0);
                end else begin
                    m0_e = q0.pop_front();
                    check("rv_owner", 32'(d_rvalid0), 32'(m0_e.owner));
                    check("rv_latency", 32'(cyc - m0_e.gcyc), 32'(c_LAT0 + 1));
                    if (!m0_e.we) begin
                        if (m0_e.owner) exp_d0 = m0_e.rdata;
                        else            exp_if0 = m0_e.rdata;
                    end
                end
            end
            check("if_rdata", if_rdata0, exp_if0);
            check("d_rdata", d_rdata0, exp_d0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (d_rvalid1) begin
                if (q1.size() == 0) begin
                    check("rv1_unexpected", 32'd1, 32'd0);
                end else begin
                    m1_e = q1.pop_front();
                    check("rv1_latency", 32'(cyc - m1_e.gcyc), 32'(c_LAT1 + 1));
                    exp_d1 = m1_e.rdata;
                end
            end
            check("rv1_if_rvalid", 32'(if_rvalid1), 32'd0);
            check("d_rdata1", d_rdata1, exp_d1);
        end
    end

    task automatic request(input logic owner, input logic we, input logic typ,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int waited);
        int start;
        bit got;
        start  = cyc;
        got    = 1'b0;
        waited = -1;
        if (owner) begin
            d_req0 = 1'b1; d_we0 = we; d_type0 = typ; d_addr0 = addr; d_wdata0 = wdata;
        end else begin
            if_req0 = 1'b1; if_addr0 = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (owner ? d_gnt0 : if_gnt0) begin
                got    = 1'b1;
                waited = cyc - start;
                check("gnt_other", 32'(owner ? if_gnt0 : d_gnt0), 32'd0);
                q0.push_back(mk(owner, we, memf(addr), cyc));
            end
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (owner) d_req0 = 1'b0;
        else       if_req0 = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   w;
        int   g[3];
        int   prev;
        logic exp_d[3];
        bit   got;

        rst = 1'b1;
        if_req0 = 0; d_req0 = 0; d_we0 = 0; d_type0 = 0;
        if_addr0 = '0; d_addr0 = '0; d_wdata0 = '0;
        if_req1 = 0; d_req1 = 0; d_we1 = 0; d_type1 = 0;
        if_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;
        prev = 0;

        // Reset state, and no grant while reset is held or before the first edge after it.
        repeat (2) @(posedge clk); #1;
        if_req0 = 1'b1; d_req0 = 1'b1;
        @(negedge clk);
        check("rst_gnt", 32'({if_gnt0, d_gnt0}), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_mem_en", 32'(mem_en0), 32'd0);
        check("rst_mem_we", 32'(mem_we0), 32'd0);
        check("rst_rvalid", 32'({if_rvalid0, d_rvalid0}), 32'd0);
        check("rst_if_rdata", if_rdata0, 32'd0);
        check("rst_d_rdata", d_rdata0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", 32'({if_gnt0, d_gnt0}), 32'd0);
        @(posedge clk); #1;
        if_req0 = 1'b0; d_req0 = 1'b0;
        @(posedge clk); #1;

        // Single fetch load, MEM_LAT=2.
        request(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, w);
        check("t1_gnt_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("t1_c1_mem_en", 32'(mem_en0), 32'd1);
        check("t1_c1_addr", mem_addr0, 32'h10);
        check("t1_c1_we", 32'(mem_we0), 32'd0);
        check("t1_c1_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        check("t1_c2_mem_en", 32'(mem_en0), 32'd1);
        check("t1_c2_rvalid", 32'(if_rvalid0), 32'd0);
        @(negedge clk);
        check("t1_c3_rvalid", 32'(if_rvalid0), 32'd1);
        check("t1_c3_mem_en", 32'(mem_en0), 32'd0);
        check("t1_c3_rdata", if_rdata0, 32'h00A00093);
        @(negedge clk);
        check("t1_c4_rvalid", 32'(if_rvalid0), 32'd0);
        check("t1_c4_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;

        // Both requesters held across three accesses.
`ifdef ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        if_req0 = 1'b1; if_addr0 = 32'h20;
        d_req0 = 1'b1; d_we0 = 1'b0; d_type0 = 1'b0; d_addr0 = 32'h40;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (if_gnt0 || d_gnt0) begin
                    got  = 1'b1;
                    g[k] = cyc;
                    check("arb_onehot", 32'(if_gnt0 & d_gnt0), 32'd0);
                    check("arb_owner", 32'(d_gnt0), 32'(exp_d[k]));
                    if (k > 0) check("arb_spacing", 32'(g[k] - g[k-1]), 32'(c_LAT0 + 2));
                    q0.push_back(mk(d_gnt0, 1'b0, memf(d_gnt0 ? d_addr0 : if_addr0), cyc));
                end
            end
            if (!got) check("arb_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        if_req0 = 1'b0; d_req0 = 1'b0;
        wait_idle();

        // Data load, then a byte store that must leave d_rdata alone.
        request(1'b1, 1'b0, 1'b0, 32'h80, 32'd0, w);
        check("t2_load_wait", 32'(w), 32'd0);
        wait_idle();
        request(1'b1, 1'b1, 1'b1, 32'h103, 32'hFF, w);
        check("t2_st_wait", 32'(w), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check("t2_mem_en", 32'(mem_en0), 32'd1);
            check("t2_mem_we", 32'(mem_we0), 32'd1);
            check("t2_mem_type", 32'(mem_type0), 32'd1);
            check("t2_mem_addr", mem_addr0, 32'h103);
            check("t2_mem_wdata", mem_wdata0, 32'hFF);
        end
        @(negedge clk);
        check("t2_rvalid", 32'(d_rvalid0), 32'd1);
        check("t2_resp_we", 32'(mem_we0), 32'd0);
        check("t2_d_rdata", d_rdata0, memf(32'h80));
        wait_idle();

        // Data request raised while a fetch is in flight.
        request(1'b0, 1'b0, 1'b0, 32'h24, 32'd0, w);
        request(1'b1, 1'b0, 1'b0, 32'h300, 32'd0, w);
        check("t40_d_wait", 32'(w), 32'(c_LAT0 + 1));
        wait_idle();

        // MEM_LAT=1 back-to-back loads.
        d_req1 = 1'b1; d_we1 = 1'b0; d_type1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_addr1 = 32'h200 + 32'(4 * k);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (d_gnt1) begin
                    got = 1'b1;
                    if (k > 0) check("t39_spacing", 32'(cyc - prev), 32'(c_LAT1 + 2));
                    prev = cyc;
                    q1.push_back(mk(1'b1, 1'b0, memf(d_addr1), cyc));
                end
            end
            if (!got) check("t39_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        d_req1 = 1'b0;
        repeat (5) @(posedge clk); #1;

        // Reset in the second access cycle aborts the load.
        request(1'b1, 1'b0, 1'b0, 32'h400, 32'd0, w);
        @(negedge clk);
        check("t38_c1_mem_en", 32'(mem_en0), 32'd1);
        @(posedge clk); #2;
        check("t38_c2_mem_en", 32'(mem_en0), 32'd1);
        rst = 1'b1;
        #1;
        check("t38_rst_mem_en", 32'(mem_en0), 32'd0);
        check("t38_rst_busy", 32'(busy0), 32'd0);
        check("t38_rst_rvalid", 32'(d_rvalid0), 32'd0);
        rst = 1'b0;
        q0.delete();
        exp_if0 = '0; exp_d0 = '0; exp_d1 = '0;
        repeat (6) @(posedge clk); #1;
        request(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, w);
        check("t38_regrant_wait", 32'(w), 32'd0);
        wait_idle();
        check("t38_if_rdata", if_rdata0, 32'h00A00093);

        check("sb0_empty", 32'(q0.size()), 32'd0);
        check("sb1_empty", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
